// File: rtl/apb4_pkg.sv
// Shared types and constants for the parametrised APB4 requester.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    // PPROT bit positions
    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NSEC_BIT   = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    // Number of bytes moved by a transfer of the given size encoding
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'd1;
            SIZE_HALF: return 4'd2;
            SIZE_WORD: return 4'd4;
            default:   return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/apb4_strb_gen.sv
// Size/alignment check and write-strobe generation for one request.
// Reads and illegal requests always produce an all-zero strobe.
module apb4_strb_gen
    import apb4_pkg::*;
#(
    parameter int STRB_WIDTH = 4
) (
    input  logic [$clog2(STRB_WIDTH)-1:0] addr_lo_i,
    input  logic [1:0]                    size_i,
    input  logic                          write_i,
    output logic [STRB_WIDTH-1:0]         strb_o,
    output logic                          err_o
);
    localparam int LW = $clog2(STRB_WIDTH);

    logic [3:0]            nbytes;
    logic [LW-1:0]         align_mask;
    logic [STRB_WIDTH-1:0] lane_mask;

    // Oversized or misaligned transfers are rejected; legal writes get their lanes shifted into place
    always_comb begin
        nbytes     = size_bytes(size_i);
        align_mask = LW'(nbytes - 4'd1);
        lane_mask  = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            lane_mask[i] = (i < int'(nbytes));
        end
        err_o  = (int'(nbytes) > STRB_WIDTH) || ((addr_lo_i & align_mask) != '0);
        strb_o = (write_i && !err_o) ? (lane_mask << addr_lo_i) : '0;
    end

endmodule

// File: rtl/apb4_master_n.sv
// APB4 requester: valid/ready request port onto an APB4 bus with NUM_SLAVES
// one-hot selects decoded from req_addr[SEL_LSB +: $clog2(NUM_SLAVES)].
// Optional feature: define APB4_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles without PREADY from the selected slave.
module apb4_master_n
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [1:0]                       req_size,
    input  logic [2:0]                       req_prot,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    output logic [2:0]                       PPROT,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    localparam int IDX_W = $clog2(NUM_SLAVES);
    localparam int LW    = $clog2(STRB_WIDTH);
    localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16 || STRB_WIDTH != DATA_WIDTH / 8 ||
        NUM_SLAVES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb4_master_n: illegal parameterisation");
    end

    apb_state_e              state_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic [2:0]              pprot_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    rsp_valid_q;
    logic                    rsp_error_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    logic [IDX_W-1:0]        idx_d;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic [STRB_WIDTH-1:0]   strb_d;
    logic                    strb_err_d;
    logic                    dec_err_d;
    logic                    req_err_d;

    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [DATA_WIDTH-1:0]   prdata_sel;

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]        tmo_q;
`endif

    assign idx_d  = req_addr[SEL_LSB +: IDX_W];
    assign psel_d = SEL_ONE << idx_d;

    // Index values past the last slave only exist when NUM_SLAVES is not a power of two
    if (NUM_SLAVES == (1 << IDX_W)) begin : g_dec_full
        assign dec_err_d = 1'b0;
    end else begin : g_dec_partial
        assign dec_err_d = (idx_d > IDX_W'(NUM_SLAVES - 1));
    end

    apb4_strb_gen #(
        .STRB_WIDTH (STRB_WIDTH)
    ) u_strb_gen (
        .addr_lo_i (req_addr[LW-1:0]),
        .size_i    (req_size),
        .write_i   (req_write),
        .strb_o    (strb_d),
        .err_o     (strb_err_d)
    );

    assign req_err_d = strb_err_d | dec_err_d;

    // Return path from the selected slave only; other slaves' PREADY/PSLVERR are ignored
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
                prdata_sel  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transfer sequencer with all bus and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB4_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr_q  <= req_addr;
                        pwrite_q <= req_write;
                        pwdata_q <= req_wdata;
                        pprot_q  <= req_prot;
                        pstrb_q  <= strb_d;
                        idx_q    <= idx_d;
                        if (req_err_d) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_SETUP;
                            psel_q  <= psel_d;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
`ifdef APB4_MASTER_TIMEOUT_EN
                    tmo_q     <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                ST_ACCESS: begin
                    if (pready_sel) begin
                        state_q     <= ST_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= pslverr_sel;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata_sel;
                    end
`ifdef APB4_MASTER_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_q     <= ST_RESP;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;

endmodule

// File: tb/tb_apb4_master_n.sv
// Bench for apb4_master_n: default 4-slave instance plus a 3-slave instance
// for the decode-error path. Expected responses go through a scoreboard queue.
module tb_apb4_master_n;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic [2:0]  req_prot = '0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSEL, PSTRB;
    logic        PENABLE, PWRITE;
    logic [2:0]  PPROT;
    logic [127:0] PRDATA;
    logic [3:0]  PREADY;
    logic [3:0]  PSLVERR = '0;

    logic        req_valid3 = 1'b0;
    logic        req_ready3, rsp_valid3, rsp_error3;
    logic [31:0] rsp_rdata3, PADDR3, PWDATA3;
    logic [2:0]  PSEL3, PPROT3;
    logic [3:0]  PSTRB3;
    logic        PENABLE3, PWRITE3;
    logic [95:0] PRDATA3 = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    logic [2:0]  PREADY3 = 3'b111;
    logic [2:0]  PSLVERR3 = 3'b000;

    logic [31:0] prd [4];
    int          ws [4];
    logic [3:0]  rdy_force = '0;
    logic [3:0]  hold_low = '0;
    int          acc_cnt = 0;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb [$];

    logic [3:0]  ph_psel, ph_pstrb;
    logic [31:0] ph_paddr, ph_pwdata;
    logic        ph_pwrite;
    logic [2:0]  ph_pprot;
    bit          psel_seen = 0;
    bit          stab_bad = 0;
    int          rsp_seen_cnt = 0;

    apb4_master_n dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb4_master_n #(.NUM_SLAVES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_prot(req_prot),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_error(rsp_error3),
        .PADDR(PADDR3), .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3),
        .PWDATA(PWDATA3), .PSTRB(PSTRB3), .PPROT(PPROT3),
        .PRDATA(PRDATA3), .PREADY(PREADY3), .PSLVERR(PSLVERR3)
    );

    always #5 clk = ~clk;

    assign PRDATA = {prd[3], prd[2], prd[1], prd[0]};

    // Slave model: ready after ws[i] extra ACCESS cycles, unless held low
    always @(posedge clk) begin
        if (PENABLE) acc_cnt <= acc_cnt + 1;
        else         acc_cnt <= 0;
    end

    always_comb begin
        PREADY = '0;
        for (int i = 0; i < 4; i++) begin
            PREADY[i] = rdy_force[i] | (PSEL[i] & PENABLE & ~hold_low[i] & (acc_cnt >= ws[i]));
        end
    end

    // Bus monitor: snapshot SETUP-phase values, flag instability or non-one-hot PSEL
    always @(negedge clk) begin
        if (rsp_valid) rsp_seen_cnt = rsp_seen_cnt + 1;
        if (PSEL != 4'b0) begin
            psel_seen = 1;
            if ($countones(PSEL) != 1) stab_bad = 1;
            if (!PENABLE) begin
                ph_psel   = PSEL;
                ph_paddr  = PADDR;
                ph_pwdata = PWDATA;
                ph_pstrb  = PSTRB;
                ph_pwrite = PWRITE;
                ph_pprot  = PPROT;
            end else if (PSEL !== ph_psel || PADDR !== ph_paddr || PWDATA !== ph_pwdata ||
                         PSTRB !== ph_pstrb || PWRITE !== ph_pwrite || PPROT !== ph_pprot) begin
                stab_bad = 1;
            end
        end
    end

    // Present a request and return #1 after the edge that accepts it
    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input logic [2:0] prot, output bit acc);
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = data; req_size = size; req_prot = prot;
        req_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 40; n++) begin
            if (req_ready) begin
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Latency 1 means rsp_valid is visible in the cycle right after the accept edge
    task automatic wait_rsp(input int budget, output bit got, output int lat, output logic [31:0] rd,
                            output logic er, output logic rdy, output logic [3:0] ps);
        got = 0; lat = 0; rd = '0; er = 1'b0; rdy = 1'b0; ps = '0;
        for (int n = 1; n <= budget; n++) begin
            if (rsp_valid) begin
                got = 1; lat = n; rd = rsp_rdata; er = rsp_error; rdy = req_ready; ps = PSEL;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1 || PSEL !== 4'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b psel=%b pen=%b rspv=%b want 1/0000/0/0",
                     req_ready, PSEL, PENABLE, rsp_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0 || PWRITE !== 1'b0 ||
            PPROT !== 3'h0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h pwrite=%b pprot=%h rdata=%h err=%b ready=%b want all 0, ready 1",
                     PADDR, PWDATA, PSTRB, PWRITE, PPROT, rsp_rdata, rsp_error, req_ready);
        end
    endtask

    task automatic test_write_word();
        bit acc, got; int lat; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        stab_bad = 0;
        drive_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 3'b010, acc);
        sb.push_back('{32'h0, 1'b0, 3});
        wait_rsp(40, got, lat, rd, er, rdy, ps);
        e = sb.pop_front();
        n_chk++;
        if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
            n_fail++;
            $display("FAIL wr_word_rsp: got=%b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                     got, lat, rd, er, e.lat, e.rdata, e.err);
        end
        n_chk++;
        if (ph_psel !== 4'b0010 || ph_pstrb !== 4'hF || ph_paddr !== 32'h0000_1004 ||
            ph_pwdata !== 32'hDEAD_BEEF || ph_pwrite !== 1'b1 || ph_pprot !== 3'b010 || stab_bad) begin
            n_fail++;
            $display("FAIL wr_word_bus: psel=%b pstrb=%h paddr=%h pwdata=%h pwrite=%b pprot=%b unstable=%b want 0010/f/00001004/deadbeef/1/010/0",
                     ph_psel, ph_pstrb, ph_paddr, ph_pwdata, ph_pwrite, ph_pprot, stab_bad);
        end
        n_chk++;
        if (rdy !== 1'b0 || ps !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_word_resp_phase: ready=%b psel=%b during rsp_valid want 0/0000", rdy, ps);
        end
    endtask

    task automatic test_read_wait();
        bit acc, got; int lat; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        stab_bad = 0;
        prd[3] = 32'h1234_5678;
        ws[3] = 2;
        rdy_force = 4'b0001;
        PSLVERR = 4'b0001;
        drive_req(1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 2'd1, 3'b001, acc);
        sb.push_back('{32'h1234_5678, 1'b0, 5});
        wait_rsp(40, got, lat, rd, er, rdy, ps);
        e = sb.pop_front();
        n_chk++;
        if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
            n_fail++;
            $display("FAIL rd_wait_rsp: got=%b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                     got, lat, rd, er, e.lat, e.rdata, e.err);
        end
        n_chk++;
        if (ph_psel !== 4'b1000 || ph_pstrb !== 4'h0 || ph_pwrite !== 1'b0 ||
            ph_paddr !== 32'h0000_3002 || stab_bad) begin
            n_fail++;
            $display("FAIL rd_wait_bus: psel=%b pstrb=%h pwrite=%b paddr=%h unstable=%b want 1000/0/0/00003002/0",
                     ph_psel, ph_pstrb, ph_pwrite, ph_paddr, stab_bad);
        end
        ws[3] = 0;
        rdy_force = '0;
        PSLVERR = '0;
    endtask

    task automatic test_strobes();
        bit acc, got; int lat; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        logic [31:0] t_addr [6];
        logic [1:0]  t_size [6];
        logic [3:0]  t_strb [6];
        logic [3:0]  t_psel [6];
        logic        t_err  [6];
        t_addr = '{32'h2003, 32'h2001, 32'h2002, 32'h0000, 32'h1006, 32'h1001};
        t_size = '{2'd0,     2'd1,     2'd1,     2'd3,     2'd2,     2'd0};
        t_strb = '{4'b1000,  4'b0000,  4'b1100,  4'b0000,  4'b0000,  4'b0010};
        t_psel = '{4'b0100,  4'b0000,  4'b0100,  4'b0000,  4'b0000,  4'b0010};
        t_err  = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
        for (int k = 0; k < 6; k++) begin
            psel_seen = 0;
            stab_bad = 0;
            drive_req(1'b1, t_addr[k], 32'h5A5A_5A5A, t_size[k], 3'b000, acc);
            sb.push_back('{32'h0, t_err[k], t_err[k] ? 1 : 3});
            wait_rsp(40, got, lat, rd, er, rdy, ps);
            e = sb.pop_front();
            n_chk++;
            if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
                n_fail++;
                $display("FAIL strb_rsp[%0d]: got=%b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                         k, got, lat, rd, er, e.lat, e.rdata, e.err);
            end
            n_chk++;
            if (t_err[k] ? psel_seen
                         : (!psel_seen || ph_psel !== t_psel[k] || ph_pstrb !== t_strb[k] || stab_bad)) begin
                n_fail++;
                $display("FAIL strb_bus[%0d]: psel_seen=%b psel=%b pstrb=%b want psel=%b pstrb=%b",
                         k, psel_seen, ph_psel, ph_pstrb, t_psel[k], t_strb[k]);
            end
        end
    endtask

    task automatic test_slverr();
        bit acc, got; int lat; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        prd[0] = 32'hA5A5_0F0F;
        PSLVERR = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            drive_req(k == 1, 32'h0000_0010, 32'h0BAD_F00D, 2'd2, 3'b000, acc);
            sb.push_back('{(k == 1) ? 32'h0 : 32'hA5A5_0F0F, 1'b1, 3});
            wait_rsp(40, got, lat, rd, er, rdy, ps);
            e = sb.pop_front();
            n_chk++;
            if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
                n_fail++;
                $display("FAIL slverr[%0d]: got=%b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                         k, got, lat, rd, er, e.lat, e.rdata, e.err);
            end
        end
        PSLVERR = '0;
    endtask

    task automatic test_back_to_back();
        bit acc, got; int lat; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        prd[0] = 32'h1111_1111;
        prd[1] = 32'h2222_2222;
        prd[2] = 32'h3333_3333;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b0, 32'(k) << 12, 32'h0, 2'd2, 3'b000, acc);
            sb.push_back('{32'h1111_1111 * (k + 1), 1'b0, 3});
            wait_rsp(40, got, lat, rd, er, rdy, ps);
            e = sb.pop_front();
            n_chk++;
            if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err || rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d]: got=%b lat=%0d rdata=%h err=%b ready=%b want lat=%0d rdata=%h err=%b ready=0",
                         k, got, lat, rd, er, rdy, e.lat, e.rdata, e.err);
            end
            @(posedge clk); #1;
            n_chk++;
            if (req_ready !== 1'b1 || PSEL !== 4'b0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: ready=%b psel=%b rspv=%b want 1/0000/0", k, req_ready, PSEL, rsp_valid);
            end
        end
    endtask

    task automatic test_decode_err();
        bit got, sel_seen; int lat; exp_t e;
        logic [31:0] t_addr [3];
        logic [2:0]  t_psel [3];
        t_addr = '{32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        t_psel = '{3'b000,        3'b100,        3'b010};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_write = 1'b0; req_addr = t_addr[k]; req_size = 2'd2; req_prot = 3'b000;
            req_valid3 = 1'b1;
            for (int n = 0; n < 40 && !req_ready3; n++) @(negedge clk);
            @(posedge clk); #1;
            req_valid3 = 1'b0;
            sb.push_back('{(k == 0) ? 32'h0 : {16'hCAFE, 16'(3 - k)}, k == 0, (k == 0) ? 1 : 3});
            got = 0; lat = 0; sel_seen = 0;
            for (int n = 1; n <= 40; n++) begin
                if (PSEL3 != 3'b000 && PSEL3 !== t_psel[k]) sel_seen = 1;
                if (PSEL3 == 3'b000 && t_psel[k] == 3'b000 && PENABLE3) sel_seen = 1;
                if (rsp_valid3) begin
                    got = 1; lat = n;
                    break;
                end
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            n_chk++;
            if (!got || lat != e.lat || rsp_rdata3 !== e.rdata || rsp_error3 !== e.err || sel_seen) begin
                n_fail++;
                $display("FAIL decode3[%0d]: got=%b lat=%0d rdata=%h err=%b bad_sel=%b want lat=%0d rdata=%h err=%b",
                         k, got, lat, rsp_rdata3, rsp_error3, sel_seen, e.lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc, got, reached; int lat; int seen0; logic [31:0] rd; logic er, rdy; logic [3:0] ps;
        hold_low[2] = 1'b1;
        drive_req(1'b0, 32'h0000_2000, 32'h0, 2'd2, 3'b000, acc);
        reached = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (PENABLE) begin
                reached = 1;
                break;
            end
        end
        seen0 = rsp_seen_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (!reached || PSEL !== 4'b0 || PENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: reached_access=%b psel=%b pen=%b want 1/0000/0", reached, PSEL, PENABLE);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold_low[2] = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (rsp_seen_cnt != seen0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after: rsp_pulses=%0d ready=%b want 0/1", rsp_seen_cnt - seen0, req_ready);
        end
        drive_req(1'b1, 32'h0000_2000, 32'h7777_0000, 2'd2, 3'b000, acc);
        sb.push_back('{32'h0, 1'b0, 3});
        wait_rsp(40, got, lat, rd, er, rdy, ps);
        n_chk++;
        if (!acc || !got || lat != sb[0].lat || er !== sb[0].err) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got=%b lat=%0d err=%b want lat=%0d err=%b", got, lat, er, sb[0].lat, sb[0].err);
        end
        void'(sb.pop_front());
    endtask

`ifdef APB4_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit acc, got; int lat; int seen0; logic [31:0] rd; logic er, rdy; logic [3:0] ps; exp_t e;
        prd[1] = 32'hFEED_FACE;
        hold_low[1] = 1'b1;
        drive_req(1'b0, 32'h0000_1000, 32'h0, 2'd2, 3'b000, acc);
        sb.push_back('{32'h0, 1'b1, 18});
        wait_rsp(60, got, lat, rd, er, rdy, ps);
        e = sb.pop_front();
        n_chk++;
        if (!acc || !got || lat != e.lat || rd !== e.rdata || er !== e.err) begin
            n_fail++;
            $display("FAIL timeout_rsp: got=%b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                     got, lat, rd, er, e.lat, e.rdata, e.err);
        end
        seen0 = rsp_seen_cnt;
        hold_low[1] = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (rsp_seen_cnt != seen0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_late: extra_rsp=%0d ready=%b want 0/1", rsp_seen_cnt - seen0, req_ready);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            prd[i] = '0;
            ws[i] = 0;
        end
        test_reset();
        test_write_word();
        test_read_wait();
        test_strobes();
        test_slverr();
        test_back_to_back();
        test_decode_err();
        test_reset_mid();
`ifdef APB4_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/apb4_master_n.md
# apb4_master_n

Parametrised APB4 requester bridging a simple valid/ready request port onto an APB4 bus with NUM_SLAVES one-hot peripheral selects. Generalises the fixed two-select APB master: address-decoded PSEL vector, per-slave PREADY/PSLVERR/PRDATA return muxing, size-derived byte strobes with alignment checking, and an optional PREADY watchdog. Sits between the system-side transaction source and the APB peripheral fabric.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (multiple of 8, ≥ 16)
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width (derived, not overridden)
- NUM_SLAVES, 4, number of selects (≥ 2)
- SEL_LSB, 12, lowest address bit of the slave index field
- TIMEOUT_CYCLES, 16, ACCESS-phase watchdog limit (≥ 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data, lane-positioned by caller
- req_size  in  2  transfer bytes = 2^req_size
- req_prot  in  3  APB4 protection attributes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 on writes/errors)
- rsp_error  out  1  completion error
- PADDR  out  ADDR_WIDTH; PSEL  out  NUM_SLAVES (one-hot); PENABLE  out  1; PWRITE  out  1; PWDATA  out  DATA_WIDTH; PSTRB  out  STRB_WIDTH; PPROT  out  3
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP. req_ready = (state == IDLE).
- Acceptance in IDLE: register PADDR, PWRITE, PWDATA, PPROT, PSTRB, slave index idx = req_addr[SEL_LSB +: $clog2(NUM_SLAVES)].
- Request error if idx ≥ NUM_SLAVES, 2^req_size > STRB_WIDTH, or req_addr not aligned to 2^req_size. Error: IDLE→RESP, no PSEL, rsp_error=1.
- Valid: IDLE→SETUP (PSEL[idx]=1, PENABLE=0) → ACCESS (PENABLE=1), held until PREADY[idx]; then → RESP. PREADY of other slaves ignored.
- On PREADY[idx] cycle capture rsp_error = PSLVERR[idx], rsp_rdata = read ? PRDATA slice idx : 0.
- RESP: rsp_valid=1 one cycle, PSEL/PENABLE low, → IDLE.
- PSTRB: writes ((1<<2^size)−1) << (req_addr mod STRB_WIDTH); reads all zero.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT stable SETUP through ACCESS end; retain last value afterwards.

## Timing
- Reset: state IDLE; req_ready=1; all other outputs 0.
- Accept at edge N: SETUP cycle N+1, ACCESS from N+2; PREADY at N+2 → rsp_valid at N+3 (min latency 3). Each wait state adds 1.
- Error request: rsp_valid at N+1.
- req_ready high during RESP cycle is false; req_ready returns in the cycle after rsp_valid; PSEL always drops ≥1 cycle between transfers.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately, no rsp_valid generated.
- No response backpressure; consumer must take rsp_valid pulse.

## Configuration
- APB4_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles; if PREADY[idx] still low after TIMEOUT_CYCLES ACCESS cycles, abort → RESP with rsp_error=1, rsp_rdata=0; late PREADY ignored.
- Undefined: ACCESS waits indefinitely; TIMEOUT_CYCLES unused, no counter logic.

## Structure
- Package apb4_pkg: state enum, size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2, SIZE_DWORD=3), PPROT bit constants.
- Sub-module apb4_strb_gen: combinational size/alignment check and strobe generation (inputs addr low bits, size, write; outputs strb, err).

## Test plan
- Write addr 0x0000_1004, size 2, wdata 0xDEADBEEF, PREADY[1] immediate → PSEL=4'b0010, PSTRB=4'hF, rsp_valid 3 cycles after accept, rsp_error=0.
- Read addr 0x0000_3002, size 1, PREADY[3] after 2 wait states, PRDATA slice 3 = 0x1234_5678 → PSTRB=0, rsp_rdata=0x1234_5678, latency 5.
- Byte write addr 0x0000_2003 → PSTRB=4'b1000; half write addr 0x0000_2001 → no PSEL, rsp_error=1 at N+1.
- NUM_SLAVES=3, addr 0x0000_3000 → decode error, PSEL stays 0, rsp_error=1.
- PSLVERR[0]=1 with PREADY[0] on read → rsp_error=1, rsp_rdata=PRDATA slice 0; with APB4_MASTER_TIMEOUT_EN, PREADY held low → abort after 16 ACCESS cycles, rsp_error=1.
- rst_n low during ACCESS → PSEL/PENABLE 0 asynchronously, no rsp_valid, req_ready=1 after release.
